// File: rtl/plane_stepper_if.sv
// Pixel output stream of the plane stepper: valid/ready handshake carrying
// the pixel coordinate, its interpolated value and the end-of-tile marker.
`timescale 1ns/1ps
interface plane_stepper_if;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_x;
    logic [10:0] out_y;
    logic [31:0] out_value;
    logic        out_last;

    modport master (
        output out_valid,
        output out_x,
        output out_y,
        output out_value,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_x,
        input  out_y,
        input  out_value,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/plane_stepper.sv
// Incremental plane evaluator: one setup cycle computes the tile-origin value,
// then every pixel of the tile is produced in raster order using additions only.
`timescale 1ns/1ps
module plane_stepper #(
    parameter int TILE_W = 32,
    parameter int TILE_H = 32,
    parameter int ACC_W  = 48
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] ddx,
    input  logic [31:0] ddy,
    input  logic [47:0] c,
    input  logic [10:0] tile_x,
    input  logic [10:0] tile_y,
    output logic        busy,
    output logic        done,
    plane_stepper_if.master stream
);

    localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(TILE_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(TILE_H - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    logic [1:0]       state_r,   state_s;
    logic             busy_r,    busy_s;
    logic             valid_r,   valid_s;
    logic             last_r,    last_s;
    logic             done_r,    done_s;
    logic [CW-1:0]    col_r,     col_s;
    logic [RW-1:0]    row_r,     row_s;
    logic [ACC_W-1:0] row_acc_r, row_acc_s;
    logic [ACC_W-1:0] pix_acc_r, pix_acc_s;
    logic [10:0]      x_r,       x_s;
    logic [10:0]      y_r,       y_s;
    logic             latch_s;

    logic [31:0]      ddx_r;
    logic [31:0]      ddy_r;
    logic [47:0]      c_r;
    logic [10:0]      tile_x_r;
    logic [10:0]      tile_y_r;

    logic [ACC_W-1:0] ddx_ext_s;
    logic [ACC_W-1:0] ddy_ext_s;
    logic [ACC_W-1:0] c_ext_s;
    logic [ACC_W-1:0] tx_ext_s;
    logic [ACC_W-1:0] ty_ext_s;
    logic [ACC_W-1:0] setup_acc_s;

    // Steps and constant are signed; tile origin is an unsigned pixel position.
    assign ddx_ext_s   = ACC_W'($signed(ddx_r));
    assign ddy_ext_s   = ACC_W'($signed(ddy_r));
    assign c_ext_s     = ACC_W'($signed(c_r));
    assign tx_ext_s    = ACC_W'(tile_x_r);
    assign ty_ext_s    = ACC_W'(tile_y_r);
    assign setup_acc_s = c_ext_s + (tx_ext_s * ddx_ext_s) + (ty_ext_s * ddy_ext_s);

    // Next-state and datapath update; flush overrides any transition or handshake.
    always_comb begin
        state_s   = state_r;
        busy_s    = busy_r;
        valid_s   = valid_r;
        last_s    = last_r;
        done_s    = 1'b0;
        col_s     = col_r;
        row_s     = row_r;
        row_acc_s = row_acc_r;
        pix_acc_s = pix_acc_r;
        x_s       = x_r;
        y_s       = y_r;
        latch_s   = 1'b0;
        if (flush) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            valid_s = 1'b0;
            last_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_SETUP;
                        busy_s  = 1'b1;
                        latch_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_s   = ST_EMIT;
                    valid_s   = 1'b1;
                    row_acc_s = setup_acc_s;
                    pix_acc_s = setup_acc_s;
                    col_s     = {CW{1'b0}};
                    row_s     = {RW{1'b0}};
                    x_s       = tile_x_r;
                    y_s       = tile_y_r;
                    last_s    = 1'b0;
                end
                ST_EMIT: begin
                    if (valid_r && stream.out_ready) begin
                        if (last_r) begin
                            state_s = ST_IDLE;
                            valid_s = 1'b0;
                            busy_s  = 1'b0;
                            last_s  = 1'b0;
                            done_s  = 1'b1;
                        end else if (col_r != COL_MAX) begin
                            col_s     = col_r + CW'(1);
                            pix_acc_s = pix_acc_r + ddx_ext_s;
                            x_s       = x_r + 11'd1;
                            last_s    = ((col_r + CW'(1)) == COL_MAX) && (row_r == ROW_MAX);
                        end else begin
                            // Row wrap: the next pixel value is the new row start.
                            col_s     = {CW{1'b0}};
                            row_s     = row_r + RW'(1);
                            row_acc_s = row_acc_r + ddy_ext_s;
                            pix_acc_s = row_acc_r + ddy_ext_s;
                            x_s       = tile_x_r;
                            y_s       = y_r + 11'd1;
                            last_s    = 1'b0;
                        end
                    end else begin
                        state_s = ST_EMIT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end
            endcase
        end
    end

    // Control and datapath state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
            col_r     <= {CW{1'b0}};
            row_r     <= {RW{1'b0}};
            row_acc_r <= {ACC_W{1'b0}};
            pix_acc_r <= {ACC_W{1'b0}};
            x_r       <= 11'd0;
            y_r       <= 11'd0;
        end else begin
            state_r   <= state_s;
            busy_r    <= busy_s;
            valid_r   <= valid_s;
            last_r    <= last_s;
            done_r    <= done_s;
            col_r     <= col_s;
            row_r     <= row_s;
            row_acc_r <= row_acc_s;
            pix_acc_r <= pix_acc_s;
            x_r       <= x_s;
            y_r       <= y_s;
        end
    end

    // Coefficient capture on an accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ddx_r    <= 32'd0;
            ddy_r    <= 32'd0;
            c_r      <= 48'd0;
            tile_x_r <= 11'd0;
            tile_y_r <= 11'd0;
        end else if (latch_s) begin
            ddx_r    <= ddx;
            ddy_r    <= ddy;
            c_r      <= c;
            tile_x_r <= tile_x;
            tile_y_r <= tile_y;
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign stream.out_valid = valid_r;
    assign stream.out_last  = last_r;
    assign stream.out_x     = x_r;
    assign stream.out_y     = y_r;
    assign stream.out_value = pix_acc_r[31:0];

endmodule
